// File: rtl/c7baxi_sram_slave.sv
// AXI4 responder backed by a word-addressed SRAM array; independent read and write engines.
// Latency: first R beat READ_LAT+1 cycles after the AR handshake, then one beat per cycle; B one cycle after W last.
// Backpressure: R data/last/resp and B held stable until r_ready/b_ready; one transaction outstanding per direction.
// Ports: clk/resetn; AR (id/addr/len/size/burst) + R (id/data/resp/last); AW (as AR) + W (data/strb/last) + B (id/resp).
module c7baxi_sram_slave #(
  parameter int ADDR_WIDTH = 10,
  parameter int READ_LAT   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s_ar_valid,
  output logic        s_ar_ready,
  input  logic [3:0]  s_ar_id,
  input  logic [31:0] s_ar_addr,
  input  logic [7:0]  s_ar_len,
  input  logic [2:0]  s_ar_size,
  input  logic [1:0]  s_ar_burst,
  output logic        s_r_valid,
  input  logic        s_r_ready,
  output logic [3:0]  s_r_id,
  output logic [31:0] s_r_data,
  output logic [1:0]  s_r_resp,
  output logic        s_r_last,
  input  logic        s_aw_valid,
  output logic        s_aw_ready,
  input  logic [3:0]  s_aw_id,
  input  logic [31:0] s_aw_addr,
  input  logic [7:0]  s_aw_len,
  input  logic [2:0]  s_aw_size,
  input  logic [1:0]  s_aw_burst,
  input  logic        s_w_valid,
  output logic        s_w_ready,
  input  logic [31:0] s_w_data,
  input  logic [3:0]  s_w_strb,
  input  logic        s_w_last,
  output logic        s_b_valid,
  input  logic        s_b_ready,
  output logic [3:0]  s_b_id,
  output logic [1:0]  s_b_resp
);

  localparam int         DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [3:0] RLAT   = 4'(READ_LAT);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {RIDLE, RWAIT, RDATA} rstate_t;
  typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wstate_t;

  logic [31:0] r_mem [DEPTH];

  // ---------------- read engine ----------------
  rstate_t               r_rstate, w_rstate_nxt;
  logic [31:0]           r_raddr;
  logic [7:0]            r_rlen, r_rbeat;
  logic                  r_rfixed, r_rerr;
  logic [3:0]            r_rcnt;
  logic                  r_ar_ready, r_r_valid, r_r_last;
  logic [3:0]            r_r_id;
  logic [31:0]           r_r_data;
  logic [1:0]            r_r_resp;

  logic                  w_ar_hs, w_r_hs, w_rwait_done, w_rload_err;
  logic [31:0]           w_raddr_nxt, w_rload_dat;
  logic [ADDR_WIDTH-1:0] w_rload_idx;

  assign w_ar_hs      = s_ar_valid & r_ar_ready;
  assign w_r_hs       = r_r_valid & s_r_ready;
  assign w_rwait_done = (r_rcnt == RLAT);
  assign w_raddr_nxt  = r_rfixed ? r_raddr : r_raddr + 32'd4;

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      RIDLE:   if (w_ar_hs) w_rstate_nxt = (READ_LAT > 0) ? RWAIT : RDATA;
      RWAIT:   if (w_rwait_done) w_rstate_nxt = RDATA;
      RDATA:   if (w_r_hs && r_r_last) w_rstate_nxt = RIDLE;
      default: w_rstate_nxt = RIDLE;
    endcase
  end

  // Word to load into r_data this cycle: the incoming AR address when there
  // is no wait state, the latched address on wait exit, the next address on
  // a beat handshake. A bad size forces zero data.
  always_comb begin
    w_rload_idx = r_raddr[ADDR_WIDTH+1:2];
    w_rload_err = r_rerr;
    case (r_rstate)
      RIDLE: begin
        w_rload_idx = s_ar_addr[ADDR_WIDTH+1:2];
        w_rload_err = (s_ar_size != 3'b010);
      end
      RDATA:   w_rload_idx = w_raddr_nxt[ADDR_WIDTH+1:2];
      default: w_rload_idx = r_raddr[ADDR_WIDTH+1:2];
    endcase
    w_rload_dat = w_rload_err ? 32'd0 : r_mem[w_rload_idx];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstate   <= RIDLE;
      r_ar_ready <= 1'b0;
      r_r_valid  <= 1'b0;
      r_r_id     <= '0;
      r_r_data   <= '0;
      r_r_resp   <= OKAY;
      r_r_last   <= 1'b0;
      r_raddr    <= '0;
      r_rlen     <= '0;
      r_rbeat    <= '0;
      r_rfixed   <= 1'b0;
      r_rerr     <= 1'b0;
      r_rcnt     <= '0;
    end else begin
      r_rstate   <= w_rstate_nxt;
      r_ar_ready <= (w_rstate_nxt == RIDLE);
      case (r_rstate)
        RIDLE: if (w_ar_hs) begin
          r_r_id   <= s_ar_id;
          r_raddr  <= s_ar_addr;
          r_rlen   <= s_ar_len;
          r_rbeat  <= '0;
          r_rfixed <= (s_ar_burst == 2'b00);
          r_rerr   <= w_rload_err;
          r_rcnt   <= '0;
          if (READ_LAT == 0) begin
            r_r_data  <= w_rload_dat;
            r_r_resp  <= w_rload_err ? SLVERR : OKAY;
            r_r_last  <= (s_ar_len == 8'd0);
            r_r_valid <= 1'b1;
          end
        end
        RWAIT: begin
          if (w_rwait_done) begin
            r_r_data  <= w_rload_dat;
            r_r_resp  <= w_rload_err ? SLVERR : OKAY;
            r_r_last  <= (r_rlen == 8'd0);
            r_r_valid <= 1'b1;
          end else begin
            r_rcnt <= r_rcnt + 4'd1;
          end
        end
        RDATA: if (w_r_hs) begin
          if (r_r_last) begin
            r_r_valid <= 1'b0;
            r_r_last  <= 1'b0;
          end else begin
            r_rbeat  <= r_rbeat + 8'd1;
            r_raddr  <= w_raddr_nxt;
            r_r_data <= w_rload_dat;
            r_r_last <= ((r_rbeat + 8'd1) == r_rlen);
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ar_ready = r_ar_ready;
  assign s_r_valid  = r_r_valid;
  assign s_r_id     = r_r_id;
  assign s_r_data   = r_r_data;
  assign s_r_resp   = r_r_resp;
  assign s_r_last   = r_r_last;

  // ---------------- write engine ----------------
  wstate_t     r_wstate, w_wstate_nxt;
  logic [31:0] r_waddr;
  logic [7:0]  r_wlen, r_wbeat;
  logic        r_wfixed, r_werr;
  logic        r_aw_ready, r_w_ready, r_b_valid;
  logic [3:0]  r_b_id;
  logic [1:0]  r_b_resp;
  logic        w_aw_hs, w_w_hs, w_b_hs, w_wen;

  assign w_aw_hs = s_aw_valid & r_aw_ready;
  assign w_w_hs  = s_w_valid & r_w_ready;
  assign w_b_hs  = r_b_valid & s_b_ready;
  assign w_wen   = w_w_hs & ~r_werr;

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      WIDLE:   if (w_aw_hs) w_wstate_nxt = WDATA;
      WDATA:   if (w_w_hs && s_w_last) w_wstate_nxt = WRESP;
      WRESP:   if (w_b_hs) w_wstate_nxt = WIDLE;
      default: w_wstate_nxt = WIDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wstate   <= WIDLE;
      r_aw_ready <= 1'b0;
      r_w_ready  <= 1'b0;
      r_b_valid  <= 1'b0;
      r_b_id     <= '0;
      r_b_resp   <= OKAY;
      r_waddr    <= '0;
      r_wlen     <= '0;
      r_wbeat    <= '0;
      r_wfixed   <= 1'b0;
      r_werr     <= 1'b0;
    end else begin
      r_wstate   <= w_wstate_nxt;
      r_aw_ready <= (w_wstate_nxt == WIDLE);
      r_w_ready  <= (w_wstate_nxt == WDATA);
      r_b_valid  <= (w_wstate_nxt == WRESP);
      if (r_wstate == WIDLE && w_aw_hs) begin
        r_b_id   <= s_aw_id;
        r_waddr  <= s_aw_addr;
        r_wlen   <= s_aw_len;
        r_wbeat  <= '0;
        r_wfixed <= (s_aw_burst == 2'b00);
        r_werr   <= (s_aw_size != 3'b010);
      end
      if (w_w_hs) begin
        r_wbeat <= r_wbeat + 8'd1;
        r_waddr <= r_wfixed ? r_waddr : r_waddr + 32'd4;
        // An early or late w_last still closes the burst but flags the response.
        if (s_w_last) r_b_resp <= (r_werr || (r_wbeat != r_wlen)) ? SLVERR : OKAY;
      end
    end
  end

  // Array has no reset; reads elsewhere see the pre-edge value (read-before-write).
  always_ff @(posedge clk) begin
    if (w_wen) begin
      for (int i = 0; i < 4; i++) begin
        if (s_w_strb[i]) r_mem[r_waddr[ADDR_WIDTH+1:2]][8*i +: 8] <= s_w_data[8*i +: 8];
      end
    end
  end

  assign s_aw_ready = r_aw_ready;
  assign s_w_ready  = r_w_ready;
  assign s_b_valid  = r_b_valid;
  assign s_b_id     = r_b_id;
  assign s_b_resp   = r_b_resp;

endmodule

// File: tb/tb_c7baxi_sram_slave.sv
// Directed bench for c7baxi_sram_slave: expected R beats and B responses are
// queued when a transaction is issued and checked as the DUT presents them.
module tb_c7baxi_sram_slave;
  logic        clk = 1'b0;
  logic        resetn;
  logic        s_ar_valid, s_ar_ready;
  logic [3:0]  s_ar_id;
  logic [31:0] s_ar_addr;
  logic [7:0]  s_ar_len;
  logic [2:0]  s_ar_size;
  logic [1:0]  s_ar_burst;
  logic        s_r_valid, s_r_ready;
  logic [3:0]  s_r_id;
  logic [31:0] s_r_data;
  logic [1:0]  s_r_resp;
  logic        s_r_last;
  logic        s_aw_valid, s_aw_ready;
  logic [3:0]  s_aw_id;
  logic [31:0] s_aw_addr;
  logic [7:0]  s_aw_len;
  logic [2:0]  s_aw_size;
  logic [1:0]  s_aw_burst;
  logic        s_w_valid, s_w_ready;
  logic [31:0] s_w_data;
  logic [3:0]  s_w_strb;
  logic        s_w_last;
  logic        s_b_valid, s_b_ready;
  logic [3:0]  s_b_id;
  logic [1:0]  s_b_resp;

  c7baxi_sram_slave #(.ADDR_WIDTH(10), .READ_LAT(1)) dut (
    .clk(clk), .resetn(resetn),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr),
    .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] ew [16];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: compare whatever the DUT presents against the queue head;
  // pop only when the beat is actually taken at the next edge.
  always @(negedge clk) begin
    if (resetn === 1'b1 && s_r_valid === 1'b1) begin
      if (rq.size() == 0) check("r_unexpected", 32'(s_r_valid), 32'd0);
      else begin
        check("r_data", s_r_data, rq[0].dat);
        check("r_id", 32'(s_r_id), 32'(rq[0].id));
        check("r_resp", 32'(s_r_resp), 32'(rq[0].resp));
        check("r_last", 32'(s_r_last), 32'(rq[0].last));
        if (s_r_ready) void'(rq.pop_front());
      end
    end
    if (resetn === 1'b1 && s_b_valid === 1'b1) begin
      if (bq.size() == 0) check("b_unexpected", 32'(s_b_valid), 32'd0);
      else begin
        check("b_id", 32'(s_b_id), 32'(bq[0].id));
        check("b_resp", 32'(s_b_resp), 32'(bq[0].resp));
        if (s_b_ready) void'(bq.pop_front());
      end
    end
  end

  task automatic push_r(input logic [3:0] id, input logic [7:0] len, input bit err);
    rexp_t e;
    for (int i = 0; i <= int'(len); i++) begin
      e.dat  = err ? 32'd0 : ew[i];
      e.id   = id;
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (i == int'(len));
      rq.push_back(e);
    end
  endtask

  task automatic ar_issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(posedge clk); #1;
    s_ar_id = id; s_ar_addr = addr; s_ar_len = len; s_ar_size = size; s_ar_burst = burst;
    s_ar_valid = 1'b1;
    @(negedge clk);
    while (!s_ar_ready && n < 50) begin @(negedge clk); n++; end
    check("ar_hs_wait", 32'(s_ar_ready), 32'd1);
    @(posedge clk); #1;
    s_ar_valid = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit toggle, input bit chklat);
    int cyc = 0;
    bit was_vld;
    push_r(id, len, size != 3'b010);
    ar_issue(id, addr, len, size, burst);
    s_r_ready = 1'b1;
    while (rq.size() > 0 && cyc < 300) begin
      @(negedge clk);
      was_vld = s_r_valid;
      if (chklat && cyc < 2) check("r_lat_idle", 32'(s_r_valid), 32'd0);
      if (chklat && cyc == 2) check("r_lat_first", 32'(s_r_valid), 32'd1);
      @(posedge clk); #1;
      if (toggle && was_vld) s_r_ready = ~s_r_ready;
      cyc++;
    end
    check("r_drain", 32'(rq.size()), 32'd0);
    s_r_ready = 1'b1;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                          input logic [1:0] bresp, input bit early, input bit bstall);
    bexp_t e;
    int n;
    e.id = id; e.resp = bresp;
    bq.push_back(e);
    if (bstall) s_b_ready = 1'b0;
    @(posedge clk); #1;
    if (early) begin
      s_w_valid = 1'b1; s_w_data = wd[0]; s_w_strb = ws[0]; s_w_last = (nbeats == 1);
      repeat (2) begin
        @(negedge clk);
        check("w_rdy_before_aw", 32'(s_w_ready), 32'd0);
      end
      @(posedge clk); #1;
    end
    s_aw_id = id; s_aw_addr = addr; s_aw_len = len; s_aw_size = size; s_aw_burst = burst;
    s_aw_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_aw_ready && n < 50) begin @(negedge clk); n++; end
    check("aw_hs_wait", 32'(s_aw_ready), 32'd1);
    @(posedge clk); #1;
    s_aw_valid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      s_w_valid = 1'b1; s_w_data = wd[i]; s_w_strb = ws[i]; s_w_last = (i == nbeats - 1);
      n = 0;
      @(negedge clk);
      while (!s_w_ready && n < 50) begin @(negedge clk); n++; end
      check("w_hs_wait", 32'(s_w_ready), 32'd1);
      @(posedge clk); #1;
    end
    s_w_valid = 1'b0; s_w_last = 1'b0;
    if (bstall) begin
      repeat (3) begin
        @(negedge clk);
        check("b_held", 32'(s_b_valid), 32'd1);
      end
      @(posedge clk); #1;
      s_b_ready = 1'b1;
    end
    n = 0;
    while (bq.size() > 0 && n < 100) begin @(posedge clk); #1; n++; end
    check("b_drain", 32'(bq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn = 1'b0;
    s_ar_valid = 0; s_ar_id = 0; s_ar_addr = 0; s_ar_len = 0; s_ar_size = 3'b010; s_ar_burst = 2'b01;
    s_aw_valid = 0; s_aw_id = 0; s_aw_addr = 0; s_aw_len = 0; s_aw_size = 3'b010; s_aw_burst = 2'b01;
    s_w_valid = 0; s_w_data = 0; s_w_strb = 0; s_w_last = 0;
    s_r_ready = 1'b1; s_b_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 4'hF; ew[i] = '0; end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ar_ready", 32'(s_ar_ready), 32'd0);
    check("rst_aw_ready", 32'(s_aw_ready), 32'd0);
    check("rst_w_ready", 32'(s_w_ready), 32'd0);
    check("rst_r_valid", 32'(s_r_valid), 32'd0);
    check("rst_b_valid", 32'(s_b_valid), 32'd0);
    check("rst_r_data", s_r_data, 32'd0);
    check("rst_r_id", 32'(s_r_id), 32'd0);
    check("rst_r_resp", 32'(s_r_resp), 32'd0);
    check("rst_r_last", 32'(s_r_last), 32'd0);
    check("rst_b_id", 32'(s_b_id), 32'd0);
    check("rst_b_resp", 32'(s_b_resp), 32'd0);
    resetn = 1'b1;
    @(posedge clk); @(negedge clk);
    check("idle_ar_ready", 32'(s_ar_ready), 32'd1);
    check("idle_aw_ready", 32'(s_aw_ready), 32'd1);
    check("idle_w_ready", 32'(s_w_ready), 32'd0);

    // Single write with early W and stalled B, then read back
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(4'h3, 32'h10, 8'd0, 3'b010, 2'b01, 1, 2'b00, 1'b1, 1'b1);
    ew[0] = 32'hDEADBEEF;
    do_read(4'h5, 32'h10, 8'd0, 3'b010, 2'b01, 1'b0, 1'b1);

    // Byte strobes
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(4'h1, 32'h20, 8'd0, 3'b010, 2'b01, 1, 2'b00, 1'b0, 1'b0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    do_write(4'h2, 32'h20, 8'd0, 3'b010, 2'b01, 1, 2'b00, 1'b0, 1'b0);
    ws[0] = 4'hF;
    ew[0] = 32'h11BB33DD;
    do_read(4'h7, 32'h20, 8'd0, 3'b010, 2'b01, 1'b0, 1'b0);

    // INCR burst write, then INCR read with r_ready toggling
    for (int i = 0; i < 4; i++) wd[i] = 32'hA5A50040 + 32'(i);
    do_write(4'h4, 32'h40, 8'd3, 3'b010, 2'b01, 4, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ew[i] = 32'hA5A50040 + 32'(i);
    do_read(4'hA, 32'h40, 8'd3, 3'b010, 2'b01, 1'b1, 1'b1);

    // FIXED write: last beat wins
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3;
    do_write(4'h6, 32'h80, 8'd2, 3'b010, 2'b00, 3, 2'b00, 1'b0, 1'b0);
    ew[0] = 32'd3;
    do_read(4'h6, 32'h80, 8'd0, 3'b010, 2'b01, 1'b0, 1'b0);

    // FIXED read repeats the same word
    for (int i = 0; i < 3; i++) ew[i] = 32'hA5A50040;
    do_read(4'hB, 32'h40, 8'd2, 3'b010, 2'b00, 1'b0, 1'b0);

    // Index wrap at the top of the array, for write and read
    wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002;
    do_write(4'h8, 32'hFFC, 8'd1, 3'b010, 2'b01, 2, 2'b00, 1'b0, 1'b0);
    ew[0] = 32'hCAFE0002;
    do_read(4'h8, 32'h000, 8'd0, 3'b010, 2'b01, 1'b0, 1'b0);
    ew[0] = 32'hCAFE0001; ew[1] = 32'hCAFE0002;
    do_read(4'h9, 32'hFFC, 8'd1, 3'b010, 2'b01, 1'b0, 1'b0);

    // Size error on read: zero data, SLVERR on every beat
    do_read(4'hC, 32'h40, 8'd1, 3'b001, 2'b01, 1'b0, 1'b0);

    // Size error on write: SLVERR, memory unchanged
    wd[0] = 32'h12345678;
    do_write(4'hD, 32'h10, 8'd0, 3'b001, 2'b01, 1, 2'b10, 1'b0, 1'b0);
    ew[0] = 32'hDEADBEEF;
    do_read(4'hD, 32'h10, 8'd0, 3'b010, 2'b01, 1'b0, 1'b0);

    // Early w_last on beat 1 of a len=3 burst: two words written, SLVERR
    for (int i = 0; i < 4; i++) wd[i] = 32'h50000000 + 32'(i);
    do_write(4'h1, 32'h100, 8'd3, 3'b010, 2'b01, 4, 2'b00, 1'b0, 1'b0);
    wd[0] = 32'h60000000; wd[1] = 32'h60000001;
    do_write(4'hE, 32'h100, 8'd3, 3'b010, 2'b01, 2, 2'b10, 1'b0, 1'b0);
    ew[0] = 32'h60000000; ew[1] = 32'h60000001; ew[2] = 32'h50000002; ew[3] = 32'h50000003;
    do_read(4'hE, 32'h100, 8'd3, 3'b010, 2'b01, 1'b0, 1'b0);

    // Reset during beat 2 of a len=7 read
    for (int i = 0; i < 8; i++) wd[i] = 32'h70000000 + 32'(i);
    do_write(4'h2, 32'h300, 8'd7, 3'b010, 2'b01, 8, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ew[i] = 32'h70000000 + 32'(i);
    push_r(4'hF, 8'd7, 1'b0);
    ar_issue(4'hF, 32'h300, 8'd7, 3'b010, 2'b01);
    n = 0;
    while (rq.size() > 6 && n < 50) begin @(posedge clk); #1; n++; end
    check("rst_mid_prep", 32'(rq.size()), 32'd6);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_r_valid", 32'(s_r_valid), 32'd0);
    check("rst_mid_ar_ready", 32'(s_ar_ready), 32'd0);
    rq.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_rel_ar_ready", 32'(s_ar_ready), 32'd1);
    check("rst_rel_r_valid", 32'(s_r_valid), 32'd0);
    ew[0] = 32'hDEADBEEF;
    do_read(4'h3, 32'h10, 8'd0, 3'b010, 2'b01, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
